demux_1x2_stream: RTL
=====================

# demux_1x2_stream

Registered 1-to-2 stream demultiplexer: the write-side counterpart of `mux_2x1`, steering one `width`-bit input stream to either of two output channels. A valid/ready handshake on every port, plus a one-entry output register per channel, keep back-pressure on one channel from corrupting the other. Per-channel transfer counters support debug and test. It sits upstream of consumers that previously received data merged by `mux_2x1`.

## Interface
- `width`, 16: data width of input and both outputs.
- `cnt_w`, 8: width of each per-channel transfer counter.

- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `enable`  input  1  global accept enable; 0 blocks new transfers.
- `sel`  input  1  destination: 0 → channel 1, 1 → channel 2.
- `in_data`  input  width  input payload.
- `in_valid`  input  1  input payload valid.
- `in_ready`  output  1  block can accept this cycle.
- `out1_data`  output  width  channel 1 payload.
- `out1_valid`  output  1  channel 1 payload valid.
- `out1_ready`  input  1  channel 1 consumer ready.
- `out2_data`  output  width  channel 2 payload.
- `out2_valid`  output  1  channel 2 payload valid.
- `out2_ready`  input  1  channel 2 consumer ready.
- `cnt1`  output  cnt_w  accepted transfers routed to channel 1.
- `cnt2`  output  cnt_w  accepted transfers routed to channel 2.

## Operation
- Each channel has a slice with two states, EMPTY (`outX_valid`=0) and FULL (`outX_valid`=1).
- Target channel X = `sel` ? 2 : 1.
- `in_ready` = `enable` && (!`outX_valid` || `outX_ready`) for the target X only. It is combinational, with no dependence on `in_valid`.
- Accept: `in_valid` && `in_ready` at a rising edge.
- On accept, slice X loads `in_data` and goes FULL, and `cntX` increments. The other slice is unaffected.
- Slice FULL, `outX_ready`=1, no load into X: goes EMPTY. `outX_data` holds its last value.
- Slice FULL, `outX_ready`=1, load into X on the same edge: stays FULL with the new data. No bubble.
- Slice FULL, `outX_ready`=0: `outX_data` and `outX_valid` stay stable until the handshake completes.
- Counters wrap modulo 2^cnt_w and never saturate.
- `sel` is sampled only on accept edges. Changing it between transfers is legal. Changing it while `in_valid` is held with `in_ready`=0 retargets the pending word; the upstream owns that choice.
- `enable`=0: `in_ready`=0, no loads, counters frozen. Already-FULL slices still drain normally.

## Timing
- Reset (`rst_n`=0, any time, asynchronous): `out1_valid`=`out2_valid`=0, `out1_data`=`out2_data`=0, `cnt1`=`cnt2`=0. `in_ready` then follows `enable`.
- Reset mid-transfer: held words are discarded. No output handshake completes while `rst_n`=0.
- Latency: a word accepted at edge k shows `outX_valid`=1 from edge k until its handshake.
- Throughput: one word per cycle, sustained, when the target `outX_ready`=1.
- Channel 1 blocked with channel 2 free: words with `sel`=1 keep flowing while channel 1 stalls.
- Alternating `sel` with both readies high: full rate, each channel valid on alternate cycles.

## Structure
- Package `demux_pkg`: channel enum `CH1`=1'b0, `CH2`=1'b1; default `width` and `cnt_w` constants.
- Sub-module `demux_out_slice` (parameter `width`): one-entry register with a load input, valid/ready output side and `can_load` output. It is instantiated twice. The top holds target decode, `in_ready` and the counters.

## Test plan
- Reset, then `enable`=1, `sel`=0, `in_data`=16'hFFF0 for one cycle, `out1_ready`=1 → `out1_valid` for 1 cycle with 16'hFFF0; `out2_valid` stays 0; `cnt1`=1, `cnt2`=0.
- Stall, then switch: `sel`=0, 16'hFFF0 with `out1_ready`=0; then `sel`=1, 16'h0AAA → channel 1 holds 16'hFFF0 stable; 16'h0AAA is accepted and delivered on channel 2 the next cycle; `in_ready`=0 only when targeting channel 1.
- Streaming: 8 words 16'h0001..16'h0008, `sel`=1, `out2_ready`=1 → accepted on 8 consecutive edges, in-order output, no bubbles, `cnt2`=8.
- Disable: `enable`=0 with `in_valid`=1 → `in_ready`=0, counters unchanged; a pending FULL slice still drains when its ready rises.
- Counter wrap with `cnt_w`=8: 256 accepts to channel 1 → `cnt1`=0; one more → `cnt1`=1.
- Async reset: assert `rst_n` low mid-edge while both slices are FULL → valids and counters go 0 immediately, without waiting for `clk`; normal operation resumes after release.

Source files
------------

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared types and defaults for the 1-to-2 stream demultiplexer.
//   channel_e      : destination channel encoding (matches the sel input bit)
//   DEFAULT_WIDTH  : default payload width
//   DEFAULT_CNT_W  : default per-channel transfer counter width
// -----------------------------------------------------------------------------
package demux_pkg;

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } channel_e;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_CNT_W = 8;

endpackage

// File: rtl/demux_out_slice.sv
// -----------------------------------------------------------------------------
// demux_out_slice
// One-entry output register for a single demux channel (EMPTY/FULL).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : write load_data this edge (only asserted when can_load=1)
//   load_data   : payload to capture
//   out_data    : held payload (keeps last value after draining)
//   out_valid   : slice is FULL
//   out_ready   : downstream consumer ready
//   can_load    : slice is empty, or is draining on this edge
// -----------------------------------------------------------------------------
module demux_out_slice
  import demux_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] load_data,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             can_load
);

  logic [width-1:0] data_r;
  logic             valid_r;

  // A FULL slice that is handing its word off this edge frees its entry in
  // time for a new load, which is what gives full throughput without bubbles.
  assign can_load  = !valid_r || out_ready;
  assign out_data  = data_r;
  assign out_valid = valid_r;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement or process ordering.
  // NOTE: the data register is reset too (not just valid) because its value
  // is architecturally visible as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1x2_stream.sv
// -----------------------------------------------------------------------------
// demux_1x2_stream
// Registered 1-to-2 stream demultiplexer with per-channel output slices and
// per-channel accepted-transfer counters.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable                : global accept enable (0 blocks new transfers)
//   sel                   : destination, 0 -> channel 1, 1 -> channel 2
//   in_data/valid/ready   : upstream stream
//   out1_data/valid/ready : channel 1 stream
//   out2_data/valid/ready : channel 2 stream
//   cnt1, cnt2            : accepted transfers per channel, wrapping
// -----------------------------------------------------------------------------
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH,
  parameter int unsigned cnt_w = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sel,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [width-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [cnt_w-1:0] cnt1,
  output logic [cnt_w-1:0] cnt2
);

  channel_e         target;
  logic             can_load1;
  logic             can_load2;
  logic             accept;
  logic             load1;
  logic             load2;
  logic [cnt_w-1:0] cnt1_r;
  logic [cnt_w-1:0] cnt2_r;

  assign target = channel_e'(sel);

  // Only the targeted slice gates readiness, so a stalled channel never
  // blocks words headed for the other one. in_valid is deliberately absent.
  assign in_ready = enable && ((target == CH2) ? can_load2 : can_load1);
  assign accept   = in_valid && in_ready;
  assign load1    = accept && (target == CH1);
  assign load2    = accept && (target == CH2);

  demux_out_slice #(.width(width)) u_slice1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (in_data),
    .out_data  (out1_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .can_load  (can_load1)
  );

  demux_out_slice #(.width(width)) u_slice2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load2),
    .load_data (in_data),
    .out_data  (out2_data),
    .out_valid (out2_valid),
    .out_ready (out2_ready),
    .can_load  (can_load2)
  );

  // Counters wrap naturally at 2^cnt_w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1_r <= '0;
      cnt2_r <= '0;
    end else begin
      if (load1) cnt1_r <= cnt1_r + cnt_w'(1);
      if (load2) cnt2_r <= cnt2_r + cnt_w'(1);
    end
  end

  assign cnt1 = cnt1_r;
  assign cnt2 = cnt2_r;

endmodule
